// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampling tick,
// 3-sample majority vote per bit, start glitch rejection, parity/frame/break
// detection and a single-entry valid/ready holding register with overrun pulse.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | line idle, waiting for a low sample on a tick
// S_START      | qualifying the start bit; a high vote rejects it as a glitch
// S_DATA       | collecting DATA_BITS data bits, LSB first
// S_PARITY     | sampling and checking the parity bit
// S_STOP       | sampling stop bits; frame completes at the last stop decision
// S_BREAK_WAIT | break seen, waiting for the line to return high

module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W     = $clog2(OVERSAMPLE);
    localparam int MID     = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   SMP_V0    = S_W'(MID - 1);
    localparam logic [S_W-1:0]   SMP_V1    = S_W'(MID);
    localparam logic [S_W-1:0]   SMP_DEC   = S_W'(MID + 1);
    localparam logic [S_W-1:0]   SMP_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 tick;

    state_t               state_q, state_d;
    logic [S_W-1:0]       smp_q, smp_d;
    logic [3:0]           bit_q, bit_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_err_q, par_err_d;
    logic                 ferr_q, ferr_d;
    logic                 stop_one_q, stop_one_d;

    logic                 vote_bit;
    logic                 decide;
    logic                 bit_end;
    logic                 done;
    logic                 done_ferr;
    logic                 done_brk;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 break_det_q;
    logic                 overrun_q;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s      = sync2_q;
    assign tick      = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    // Free-running oversample tick divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign vote_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
    assign decide   = tick && (smp_q == SMP_DEC);
    assign bit_end  = tick && (smp_q == SMP_LAST);

    // FSM state and frame-assembly registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            smp_q      <= '0;
            bit_q      <= '0;
            vote_q     <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            ferr_q     <= 1'b0;
            stop_one_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_q      <= smp_d;
            bit_q      <= bit_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
            ferr_q     <= ferr_d;
            stop_one_q <= stop_one_d;
        end
    end

    // Next-state, sampling and frame-completion decode.
    always_comb begin
        state_d    = state_q;
        smp_d      = smp_q;
        bit_d      = bit_q;
        vote_d     = vote_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_err_d  = par_err_q;
        ferr_d     = ferr_q;
        stop_one_d = stop_one_q;
        done       = 1'b0;
        done_ferr  = 1'b0;
        done_brk   = 1'b0;

        // Inside a frame the sample counter advances every tick and the two
        // early votes are captured; the third vote is the live sample.
        if (tick && (state_q != S_IDLE) && (state_q != S_BREAK_WAIT)) begin
            smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + 1'b1;
            if (smp_q == SMP_V0) vote_d[0] = rx_s;
            if (smp_q == SMP_V1) vote_d[1] = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                if (tick && !rx_s) begin
                    state_d    = S_START;
                    smp_d      = S_W'(1);
                    bit_d      = '0;
                    par_bit_d  = 1'b0;
                    par_err_d  = 1'b0;
                    ferr_d     = 1'b0;
                    stop_one_d = 1'b0;
                end
            end
            S_START: begin
                if (decide && vote_bit) begin
                    state_d = S_IDLE;
                    smp_d   = '0;
                end else if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {vote_bit, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    par_bit_d = vote_bit;
                    par_err_d = ((vote_bit ^ (^shift_q)) != PAR_ODD);
                end
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (decide) begin
                    if (!vote_bit) ferr_d = 1'b1;
                    if (vote_bit)  stop_one_d = 1'b1;
                    // Completing at mid-stop lets the next start edge be
                    // caught even if the transmitter runs slightly fast.
                    if (bit_q == STOP_LAST) begin
                        done      = 1'b1;
                        done_ferr = ferr_q | ~vote_bit;
                        done_brk  = (shift_q == '0) && ((PARITY == 0) || !par_bit_q)
                                    && !stop_one_q && !vote_bit;
                        state_d   = done_brk ? S_BREAK_WAIT : S_IDLE;
                        smp_d     = '0;
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_BREAK_WAIT: begin
                if (tick && rx_s) begin
                    state_d = S_IDLE;
                    smp_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                smp_d   = '0;
            end
        endcase
    end

    // Holding register with valid/ready handshake and overrun/break pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            break_det_q <= done && done_brk;
            overrun_q   <= 1'b0;
            if (done) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= shift_q;
                    parity_err_q <= (PARITY != 0) && par_err_q;
                    frame_err_q  <= done_ferr;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and a 7E2 instance share clock and
// reset. Frames are built bit by bit from their data; expected words and
// flags come from the framing rules applied to those bits.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int OS       = 16;
    localparam int DIVV     = 2;
    localparam int BAUD     = 115_200;
    localparam int CLKF     = BAUD * OS * DIVV;
    localparam int BIT_CLKS = OS * DIVV;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd_a, rxd_b, rdy_a, rdy_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       val_a, pe_a, fe_a, brk_a, ovr_a, busy_a;
    logic       val_b, pe_b, fe_b, brk_b, ovr_b, busy_b;

    word_t got_a[$], got_b[$], exp_a[$], exp_b[$];
    int    n_brk_a = 0, n_ovr_a = 0, n_brk_b = 0, n_ovr_b = 0, busy_cyc_a = 0;
    int    e_brk_a = 0, e_brk_b = 0;
    int    ci_a = 0, ci_b = 0;
    int    n_cmp = 0, n_bad = 0;
    logic  fb [0:15];
    int    fn;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .rxd(rxd_a), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(brk_a),
        .overrun(ovr_a), .busy(busy_a));

    uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .rxd(rxd_b), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(brk_b),
        .overrun(ovr_b), .busy(busy_b));

    // Record accepted words and output pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (val_a && rdy_a) got_a.push_back({1'b0, data_a, pe_a, fe_a});
        if (val_b && rdy_b) got_b.push_back({2'b00, data_b, pe_b, fe_b});
        if (brk_a) n_brk_a++;
        if (ovr_a) n_ovr_a++;
        if (brk_b) n_brk_b++;
        if (ovr_b) n_ovr_b++;
        if (busy_a) busy_cyc_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int nbits);
        repeat (nbits * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic play(input int which);
        for (int i = 0; i < fn; i++) begin
            if (which == 0) rxd_a = fb[i]; else rxd_b = fb[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        if (which == 0) rxd_a = 1'b1; else rxd_b = 1'b1;
    endtask

    // 8N1 frame; when mdl is set the expected word is queued.
    task automatic send_a(input logic [7:0] d, input logic stop, input bit mdl);
        fn = 0;
        fb[fn] = 1'b0; fn++;
        for (int i = 0; i < 8; i++) begin fb[fn] = d[i]; fn++; end
        fb[fn] = stop; fn++;
        if (mdl) begin
            exp_a.push_back({1'b0, d, 1'b0, ~stop});
            if (d == 8'h00 && !stop) e_brk_a++;
        end
        play(0);
        idle(2);
    endtask

    // 7E2 frame with explicit parity and stop levels.
    task automatic send_b(input logic [6:0] d, input logic par, input logic s1, input logic s2);
        fn = 0;
        fb[fn] = 1'b0; fn++;
        for (int i = 0; i < 7; i++) begin fb[fn] = d[i]; fn++; end
        fb[fn] = par; fn++;
        fb[fn] = s1; fn++;
        fb[fn] = s2; fn++;
        exp_b.push_back({2'b00, d, par ^ (^d), ~(s1 & s2)});
        if (d == 7'h00 && !par && !s1 && !s2) e_brk_b++;
        play(1);
        idle(2);
    endtask

    task automatic check_words(input int which, input string tag);
        word_t g, e;
        int    ng, ne, i0;
        ng = (which == 0) ? got_a.size() : got_b.size();
        ne = (which == 0) ? exp_a.size() : exp_b.size();
        i0 = (which == 0) ? ci_a : ci_b;
        chk({tag, " words"}, 32'(ng), 32'(ne));
        for (int i = i0; i < ng && i < ne; i++) begin
            g = (which == 0) ? got_a[i] : got_b[i];
            e = (which == 0) ? exp_a[i] : exp_b[i];
            chk({tag, " data"}, 32'(g.d), 32'(e.d));
            chk({tag, " parity_err"}, 32'(g.pe), 32'(e.pe));
            chk({tag, " frame_err"}, 32'(g.fe), 32'(e.fe));
        end
        if (which == 0) ci_a = ne; else ci_b = ne;
    endtask

    initial begin
        int   b0;
        logic [6:0] r7;
        logic flip;

        reset = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset rx_valid", 32'(val_a), 32'd0);
        chk("reset rx_data", 32'(data_a), 32'd0);
        chk("reset flags", 32'({pe_a, fe_a, brk_a, ovr_a}), 32'd0);
        chk("reset busy", 32'({busy_a, busy_b}), 32'd0);
        reset = 1'b0;
        idle(1);

        send_a(8'h55, 1'b1, 1'b1);
        chk("busy between frames", 32'(busy_a), 32'd0);
        send_a(8'hA3, 1'b1, 1'b1);
        check_words(0, "8n1 basic");
        chk("busy idle", 32'(busy_a), 32'd0);

        send_b(7'h41, 1'b0, 1'b1, 1'b1);
        send_b(7'h41, 1'b1, 1'b1, 1'b1);
        check_words(1, "7e2 parity");

        b0 = busy_cyc_a;
        rxd_a = 1'b0;
        repeat (3 * DIVV) @(posedge clk);
        #1;
        rxd_a = 1'b1;
        idle(2);
        chk("glitch busy seen", 32'(busy_cyc_a > b0), 32'd1);
        chk("glitch busy dropped", 32'(busy_a), 32'd0);
        check_words(0, "glitch");

        send_a(8'h3C, 1'b0, 1'b1);
        check_words(0, "stop low");
        chk("stop low no break", 32'(n_brk_a), 32'(e_brk_a));

        rxd_a = 1'b0;
        exp_a.push_back({9'h000, 1'b0, 1'b1});
        e_brk_a++;
        idle(20);
        chk("break waiting", 32'(busy_a), 32'd1);
        rxd_a = 1'b1;
        idle(2);
        check_words(0, "break");
        chk("break pulses", 32'(n_brk_a), 32'(e_brk_a));
        send_a(8'h7E, 1'b1, 1'b1);
        check_words(0, "after break");

        rdy_a = 1'b0;
        send_a(8'h11, 1'b1, 1'b0);
        send_a(8'h22, 1'b1, 1'b0);
        chk("overrun held valid", 32'(val_a), 32'd1);
        chk("overrun held data", 32'(data_a), 32'h11);
        chk("overrun pulses", 32'(n_ovr_a), 32'd1);
        rdy_a = 1'b1;
        exp_a.push_back({9'h011, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        chk("overrun drained", 32'(val_a), 32'd0);
        check_words(0, "overrun");

        rxd_a = 1'b0;
        idle(2);
        chk("midframe busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        rxd_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        chk("midframe abort busy", 32'(busy_a), 32'd0);
        chk("midframe abort data", 32'(data_a), 32'd0);
        check_words(0, "midframe abort");

        for (int k = 0; k < 10; k++) begin
            send_a(8'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
        end
        check_words(0, "random 8n1");

        for (int k = 0; k < 10; k++) begin
            r7   = 7'($urandom);
            flip = 1'($urandom_range(0, 1));
            send_b(r7, (^r7) ^ flip, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        check_words(1, "random 7e2");

        chk("total breaks a", 32'(n_brk_a), 32'(e_brk_a));
        chk("total breaks b", 32'(n_brk_b), 32'(e_brk_b));
        chk("total overruns a", 32'(n_ovr_a), 32'd1);
        chk("total overruns b", 32'(n_ovr_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of our fixed 8N1 receiver. Adds:
- configurable data width, parity mode and stop-bit count
- configurable oversampling with 3-sample majority vote
- start-bit glitch rejection
- parity, framing and break detection
- a valid/ready output handshake with overrun reporting

Sits between the board RX pin and the byte-consuming logic. Same clk domain.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line baud rate
OVERSAMPLE, 16, sample ticks per bit; even, 8..16
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
rxd  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word, LSB first on the line
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
parity_err  out  1  parity mismatch for the word in rx_data
frame_err  out  1  a stop bit was sampled low for the word in rx_data
break_det  out  1  one-cycle pulse: break condition detected
overrun  out  1  one-cycle pulse: completed frame dropped because the holding register was full
busy  out  1  high in any state other than IDLE

Behaviour:
- Synchroniser: rxd passes through 2 flops; both reset to 1. All decoding uses the synchronised value.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, clamped to a minimum of 1.
  - Counter runs free except during reset; one-cycle tick when the counter reaches DIV-1, then it wraps to 0.
- Sample counter s:
  - Range 0..OVERSAMPLE-1; advances on each tick.
  - Per bit, votes samples at s = M-1, M, M+1, where M = OVERSAMPLE/2.
  - Bit value = majority of the 3 votes, decided at s = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: on a tick with the synchronised line low -> START, s = 1.
  - START: at decision, voted 1 -> IDLE (glitch rejected, no outputs); voted 0 -> continue. At s = OVERSAMPLE-1 tick -> DATA, s = 0, bit index 0.
  - DATA: each decision shifts the bit into the shift register LSB-first. After DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
  - PARITY: decision compares against the XOR of the data bits (odd: total ones incl. parity odd; even: even). Then -> STOP.
  - STOP: decision at mid of each stop bit; any 0 sets the frame error. Frame completes at the decision of the last stop bit (no wait for bit end, allowing resync).
  - On completion: break if data, parity (if present) and all stop bits are 0 -> break_det pulse, word still delivered with frame_err = 1, state -> BREAK_WAIT. Otherwise -> IDLE.
  - BREAK_WAIT: stays until the synchronised line is seen high on a tick, then -> IDLE.
- Holding register / handshake:
  - On completion with rx_valid = 0, or rx_valid && rx_ready in the same cycle: load rx_data, parity_err, frame_err; rx_valid = 1 the next cycle.
  - On completion with rx_valid = 1 and rx_ready = 0: new frame discarded, overrun pulses 1 cycle, old word and flags unchanged.
  - rx_valid && rx_ready without completion: rx_valid = 0 next cycle. rx_data and flags hold their values until the next load.
  - Completion-to-rx_valid latency: 1 clk.
- Reset:
  - rx_valid, rx_data, parity_err, frame_err, break_det, overrun, busy all 0.
  - FSM -> IDLE; tick, sample and bit counters -> 0.
  - Reset mid-frame aborts the frame with no outputs.
- Width rules: bit counter wide enough for 9; parity computed over exactly DATA_BITS bits. For DATA_BITS < 9, unused shift-register bits are not visible on rx_data.

Test Plan:
- Defaults (8N1, OS 16), send 0x55 then 0xA3 with rx_ready = 1 -> two rx_valid handshakes, data 0x55/0xA3, all error flags 0, busy low between frames.
- PARITY = 2, DATA_BITS = 7, STOP_BITS = 2, send 0x41 with correct parity bit 0 -> parity_err 0. Resend with parity bit 1 -> rx_data 0x41, parity_err 1.
- Line low for 3 bit-sample ticks (< M-1) then high -> returns to IDLE, no rx_valid, busy drops.
- 8N1 frame 0x3C with stop bit driven 0 -> rx_data 0x3C, frame_err 1, break_det 0.
- Line held low for 20 bit times -> rx_data 0x00, frame_err 1, break_det pulses once. No further frame until the line returns high. Next frame 0x7E is received correctly.
- rx_ready = 0, send 0x11 then 0x22 -> rx_valid stays 1 with 0x11, overrun pulses 1 cycle at the 0x22 stop decision. Then assert rx_ready -> 0x11 accepted, rx_valid drops.
